mem_access_ctrl: RTL and testbench

Sequencer for the data-memory access performed between the EX/MEM and MEM/WB pipeline registers. It turns a load or store held in EX/MEM into a req/ack transaction on the data-memory port, holds the upstream pipeline while the access is outstanding, and injects bubbles into MEM/WB so no stale write-back occurs. Captured load data drives the `MEM_DATA` input of MEM/WB. A timeout counter flags a hung memory.

---
 rtl/mem_ctrl_pkg.sv | 14 +
 rtl/mem_timeout_ctr.sv | 36 +++
 rtl/mem_access_ctrl.sv | 118 +++++++++++
 tb/tb_mem_access_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the EX/MEM -> MEM/WB data-memory access sequencer.
package mem_ctrl_pkg;

  localparam int CNT_W       = 8;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_ERR    = 2'd3
  } state_e;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts ACCESS cycles without an acknowledge; flags the cycle that exhausts the budget.
module mem_timeout_ctr
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q holds the number of already-waited cycles, so TIMEOUT-1 marks the last one.
  assign expired = en && (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// Turns an EX/MEM load/store into a req/ack memory transaction, stalling upstream
// and bubbling MEM/WB until the access retires.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              MEM_READ,
  input  logic              MEM_WRITE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] WDATA,
  output logic              DM_REQ,
  output logic              DM_WE,
  output logic [ADDR_W-1:0] DM_ADDR,
  output logic [DATA_W-1:0] DM_WDATA,
  input  logic              DM_ACK,
  input  logic [DATA_W-1:0] DM_RDATA,
  output logic [DATA_W-1:0] LOAD_DATA,
  output logic              STALL,
  output logic              WB_BUBBLE,
  output logic              BUS_ERR
);

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] load_q, load_d;
  logic              tmo_expired;

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .clr     (state_q == ST_IDLE),
    .en      ((state_q == ST_ACCESS) && !DM_ACK),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    load_d  = load_q;
    case (state_q)
      ST_IDLE: begin
        if (MEM_READ && MEM_WRITE) begin
          err_d   = 1'b1;
          state_d = ST_ERR;
        end else if (MEM_READ ^ MEM_WRITE) begin
          req_d   = 1'b1;
          we_d    = MEM_WRITE;
          addr_d  = ADDR;
          wdata_d = WDATA;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // An acknowledge in the expiring cycle still completes the access.
        if (DM_ACK) begin
          if (!we_q) begin
            load_d = DM_RDATA;
          end
          req_d   = 1'b0;
          state_d = ST_DONE;
        end else if (tmo_expired) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = ST_ERR;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      load_q  <= load_d;
    end
  end

  assign DM_REQ    = req_q;
  assign DM_WE     = we_q;
  assign DM_ADDR   = addr_q;
  assign DM_WDATA  = wdata_q;
  assign LOAD_DATA = load_q;
  assign BUS_ERR   = err_q;
  assign STALL     = ((state_q == ST_IDLE) && (MEM_READ || MEM_WRITE)) ||
                     (state_q == ST_ACCESS) || (state_q == ST_ERR);
  assign WB_BUBBLE = STALL;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed vector table, corner sequences, random vs. model.
module tb_mem_access_ctrl;

  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd, wr, ack;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, rdata;
  logic          dm_req, dm_we, stall, wb_bubble, bus_err;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, load_data;

  int total = 0;
  int bad   = 0;

  mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .CLK       (clk),
    .RESET_N   (rst_n),
    .MEM_READ  (rd),
    .MEM_WRITE (wr),
    .ADDR      (addr),
    .WDATA     (wdata),
    .DM_REQ    (dm_req),
    .DM_WE     (dm_we),
    .DM_ADDR   (dm_addr),
    .DM_WDATA  (dm_wdata),
    .DM_ACK    (ack),
    .DM_RDATA  (rdata),
    .LOAD_DATA (load_data),
    .STALL     (stall),
    .WB_BUBBLE (wb_bubble),
    .BUS_ERR   (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr, ack;
    logic [63:0] addr, wdata, rdata;
    logic        e_req, e_we, e_stall, e_err;
    logic [63:0] e_addr, e_wdata, e_load;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic w, input logic a,
                              input logic [63:0] ad, input logic [63:0] wd, input logic [63:0] rdt,
                              input logic er, input logic ewe, input logic est, input logic eer,
                              input logic [63:0] ead, input logic [63:0] ewd, input logic [63:0] eld);
    vec_t v;
    v.rd = r; v.wr = w; v.ack = a; v.addr = ad; v.wdata = wd; v.rdata = rdt;
    v.e_req = er; v.e_we = ewe; v.e_stall = est; v.e_err = eer;
    v.e_addr = ead; v.e_wdata = ewd; v.e_load = eld;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic e_req, input logic e_we,
                               input logic e_stall, input logic e_err, input logic [63:0] e_addr,
                               input logic [63:0] e_wdata, input logic [63:0] e_load);
    check({tag, ".req"},    64'(dm_req),    64'(e_req));
    check({tag, ".stall"},  64'(stall),     64'(e_stall));
    check({tag, ".bubble"}, 64'(wb_bubble), 64'(e_stall));
    check({tag, ".err"},    64'(bus_err),   64'(e_err));
    check({tag, ".load"},   load_data,      e_load);
    if (e_req) begin
      check({tag, ".we"},    64'(dm_we), 64'(e_we));
      check({tag, ".addr"},  dm_addr,    e_addr);
      check({tag, ".wdata"}, dm_wdata,   e_wdata);
    end
  endtask

  task automatic set_in(input logic r, input logic w, input logic a, input logic [63:0] ad,
                        input logic [63:0] wd, input logic [63:0] rdt);
    rd = r; wr = w; ack = a; addr = ad; wdata = wd; rdata = rdt;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Transaction-level reference: outstanding request, retiring cycle, hung flag.
  logic        m_out, m_ret, m_hung, m_we;
  int          m_wait;
  logic [63:0] m_addr, m_wdata, m_load;

  function automatic void model_reset();
    m_out = 0; m_ret = 0; m_hung = 0; m_we = 0; m_wait = 0;
    m_addr = 0; m_wdata = 0; m_load = 0;
  endfunction

  function automatic void model_step();
    if (m_hung) begin
    end else if (m_out) begin
      if (ack) begin
        if (!m_we) m_load = rdata;
        m_out = 0;
        m_ret = 1;
      end else begin
        m_wait++;
        if (m_wait == TMO) begin
          m_out  = 0;
          m_hung = 1;
        end
      end
    end else if (m_ret) begin
      m_ret = 0;
    end else if (rd && wr) begin
      m_hung = 1;
    end else if (rd || wr) begin
      m_out = 1; m_wait = 0; m_we = wr; m_addr = addr; m_wdata = wdata;
    end
  endfunction

  task automatic check_model(input string tag);
    logic e_stall;
    e_stall = m_hung || m_out || (!m_ret && (rd || wr));
    check_outputs(tag, m_out, m_we, e_stall, m_hung, m_addr, m_wdata, m_load);
  endtask

  vec_t vecs[20];

  initial begin
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    #2;
    check_outputs("reset", 0, 0, 0, 0, 0, 0, 0);
    check("reset.we",    64'(dm_we), 64'd0);
    check("reset.addr",  dm_addr,    64'd0);
    check("reset.wdata", dm_wdata,   64'd0);
    #6 rst_n = 1'b1;

    //              rd wr ak addr    wdata   rdata          req we st er eaddr   ewdata  eload
    vecs[0]  = mk(1, 0, 0, 64'h100, 64'h0,  64'h0,          0, 0, 1, 0, 64'h0,   64'h0,  64'h0);
    vecs[1]  = mk(1, 0, 1, 64'h100, 64'h0,  64'hDEADBEEF,   1, 0, 1, 0, 64'h100, 64'h0,  64'h0);
    vecs[2]  = mk(1, 0, 0, 64'h100, 64'h0,  64'h0,          0, 0, 0, 0, 64'h0,   64'h0,  64'hDEADBEEF);
    vecs[3]  = mk(0, 0, 0, 64'h0,   64'h0,  64'h0,          0, 0, 0, 0, 64'h0,   64'h0,  64'hDEADBEEF);
    vecs[4]  = mk(0, 1, 0, 64'h20,  64'h55, 64'h0,          0, 0, 1, 0, 64'h0,   64'h0,  64'hDEADBEEF);
    vecs[5]  = mk(0, 1, 0, 64'h20,  64'h55, 64'h0,          1, 1, 1, 0, 64'h20,  64'h55, 64'hDEADBEEF);
    vecs[6]  = mk(0, 1, 0, 64'h20,  64'h55, 64'h0,          1, 1, 1, 0, 64'h20,  64'h55, 64'hDEADBEEF);
    vecs[7]  = mk(0, 1, 0, 64'h20,  64'h55, 64'h0,          1, 1, 1, 0, 64'h20,  64'h55, 64'hDEADBEEF);
    vecs[8]  = mk(0, 1, 1, 64'h20,  64'h55, 64'h1111,       1, 1, 1, 0, 64'h20,  64'h55, 64'hDEADBEEF);
    vecs[9]  = mk(0, 1, 0, 64'h20,  64'h55, 64'h0,          0, 0, 0, 0, 64'h0,   64'h0,  64'hDEADBEEF);
    vecs[10] = mk(0, 0, 0, 64'h0,   64'h0,  64'h0,          0, 0, 0, 0, 64'h0,   64'h0,  64'hDEADBEEF);
    vecs[11] = mk(1, 0, 0, 64'h300, 64'h0,  64'h0,          0, 0, 1, 0, 64'h0,   64'h0,  64'hDEADBEEF);
    vecs[12] = mk(1, 0, 1, 64'h300, 64'h0,  64'h1234,       1, 0, 1, 0, 64'h300, 64'h0,  64'hDEADBEEF);
    vecs[13] = mk(1, 0, 0, 64'h300, 64'h0,  64'h0,          0, 0, 0, 0, 64'h0,   64'h0,  64'h1234);
    vecs[14] = mk(0, 1, 0, 64'h40,  64'h99, 64'h0,          0, 0, 1, 0, 64'h0,   64'h0,  64'h1234);
    vecs[15] = mk(0, 1, 1, 64'h40,  64'h99, 64'h5555,       1, 1, 1, 0, 64'h40,  64'h99, 64'h1234);
    vecs[16] = mk(0, 1, 0, 64'h40,  64'h99, 64'h0,          0, 0, 0, 0, 64'h0,   64'h0,  64'h1234);
    vecs[17] = mk(0, 0, 0, 64'h0,   64'h0,  64'h0,          0, 0, 0, 0, 64'h0,   64'h0,  64'h1234);
    vecs[18] = mk(0, 0, 1, 64'h0,   64'h0,  64'hFFFF,       0, 0, 0, 0, 64'h0,   64'h0,  64'h1234);
    vecs[19] = mk(0, 0, 0, 64'h0,   64'h0,  64'h0,          0, 0, 0, 0, 64'h0,   64'h0,  64'h1234);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      set_in(vecs[i].rd, vecs[i].wr, vecs[i].ack, vecs[i].addr, vecs[i].wdata, vecs[i].rdata);
      #2;
      check_outputs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_we, vecs[i].e_stall,
                    vecs[i].e_err, vecs[i].e_addr, vecs[i].e_wdata, vecs[i].e_load);
    end

    // Timeout with no acknowledge, then a late ACK, then a reset pulse.
    reset_dut();
    @(negedge clk); set_in(1, 0, 0, 64'h500, 0, 0); #2;
    check("to.detect_stall", 64'(stall), 64'd1);
    for (int k = 0; k < TMO; k++) begin
      @(negedge clk); ack = 0; #2;
      check($sformatf("to.req%0d", k), 64'(dm_req), 64'd1);
      check($sformatf("to.err%0d", k), 64'(bus_err), 64'd0);
    end
    @(negedge clk); #2;
    check_outputs("to.err", 0, 0, 1, 1, 0, 0, 0);
    @(negedge clk); set_in(0, 0, 1, 0, 0, 64'h777); #2;
    @(negedge clk); ack = 0; #2;
    check_outputs("to.late_ack", 0, 0, 1, 1, 0, 0, 0);
    #1 rst_n = 1'b0;
    #1 check_outputs("to.reset", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); rst_n = 1'b1;

    // Simultaneous read and write request.
    @(negedge clk); set_in(1, 1, 0, 64'h10, 64'h20, 0); #2;
    check("cf.detect_req", 64'(dm_req), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); set_in(0, 0, 1'(k), 0, 0, 64'hAA); #2;
      check_outputs($sformatf("cf.err%0d", k), 0, 0, 1, 1, 0, 0, 0);
    end

    // ACK arriving in the cycle that would otherwise time out.
    reset_dut();
    @(negedge clk); set_in(1, 0, 0, 64'h600, 0, 0); #2;
    for (int k = 0; k < TMO - 1; k++) begin
      @(negedge clk); ack = 0; #2;
    end
    @(negedge clk); ack = 1; rdata = 64'hABC; #2;
    check("co.req_last", 64'(dm_req), 64'd1);
    @(negedge clk); ack = 0; #2;
    check_outputs("co.done", 0, 0, 0, 0, 0, 0, 64'hABC);
    @(negedge clk); rd = 0; #2;
    check_outputs("co.idle", 0, 0, 0, 0, 0, 0, 64'hABC);

    // Reset in the middle of an access, then a stray acknowledge.
    reset_dut();
    @(negedge clk); set_in(1, 0, 0, 64'h700, 0, 0); #2;
    @(negedge clk); #2;
    check("mr.req_before", 64'(dm_req), 64'd1);
    #1 rst_n = 1'b0;
    #1 check("mr.req_async", 64'(dm_req), 64'd0);
    @(negedge clk); rst_n = 1'b1; set_in(0, 0, 1, 0, 0, 64'hBAD); #2;
    check("mr.stall_idle", 64'(stall), 64'd0);
    @(negedge clk); ack = 0; #2;
    check_outputs("mr.stray", 0, 0, 0, 0, 0, 0, 0);

    // Random traffic against the reference model.
    reset_dut();
    model_reset();
    for (int n = 0; n < 1500; n++) begin
      int r;
      @(negedge clk);
      rst_n = 1'b1;
      if ($urandom_range(0, 149) == 0 || (m_hung && $urandom_range(0, 5) == 0)) begin
        rst_n = 1'b0;
        set_in(0, 0, 1'($urandom_range(0, 1)), 0, 0, 64'h5A);
        model_reset();
        #2;
        check_model("rnd_rst");
      end else begin
        r = int'($urandom_range(0, 15));
        set_in(r == 0 || r < 7, r == 0 || (r >= 7 && r < 12), $urandom_range(0, 2) == 0,
               {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
        #2;
        check_model("rnd");
        model_step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
